// File: rtl/pt_flt_pkg.sv
// Shared definitions for the pt_flt float word: opcode, field layout and the
// decoder state encoding. Imported by the CPU and by the decoder.
package pt_flt_pkg;

  localparam logic [3:0] PT_FLT_OPCODE = 4'b1101;

  localparam int FLT_BIAS  = 127;
  localparam int FLT_MAN_W = 7;
  localparam int FLT_EXP_W = 8;

  localparam int SIGN_BIT = 15;
  localparam int EXP_MSB  = 14;
  localparam int EXP_LSB  = 7;
  localparam int MAN_MSB  = 6;

  localparam int INT_W = 8;
  localparam int DEC_W = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_DIGIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/pt_flt_decoder_if.sv
// Start/busy/done handshake and result bus between the requester and the
// pt_flt decoder.
interface pt_flt_decoder_if;
  import pt_flt_pkg::*;

  logic                 start;
  logic [15:0]          flt_in;
  logic                 busy;
  logic                 done;
  logic [INT_W-1:0]     int_out;
  logic [FLT_MAN_W-1:0] frac_bin;
  logic [DEC_W-1:0]     frac_dec;
  logic                 sign_out;
  logic                 exp_err;
  logic                 zf;

  modport master (
    output start, flt_in,
    input  busy, done, int_out, frac_bin, frac_dec, sign_out, exp_err, zf
  );

  modport slave (
    input  start, flt_in,
    output busy, done, int_out, frac_bin, frac_dec, sign_out, exp_err, zf
  );

endinterface

// File: rtl/pt_flt_decoder_frac_digit_step.sv
// One decimal digit of a binary fraction: fr*10 by shift-add, the integer
// carry-out is the digit and the low bits are the remaining fraction.
module frac_digit_step #(
  parameter int MAN_W = 7
) (
  input  logic [MAN_W-1:0] fr,
  output logic [3:0]       digit,
  output logic [MAN_W-1:0] fr_next
);

  logic [MAN_W+3:0] fr_ext;
  logic [MAN_W+3:0] prod;

  assign fr_ext  = {4'b0000, fr};
  assign prod    = (fr_ext << 3) + (fr_ext << 1);
  assign digit   = prod[MAN_W+3:MAN_W];
  assign fr_next = prod[MAN_W-1:0];

endmodule

// File: rtl/pt_flt_decoder.sv
// Multi-cycle decoder for the pt_flt 16-bit float: integer part, binary
// fraction and truncated decimal fraction behind a start/busy/done handshake.
module pt_flt_decoder
  import pt_flt_pkg::*;
#(
  parameter int FRAC_DIGITS = 2,
  parameter int BIAS        = FLT_BIAS,
  parameter int MAN_W       = FLT_MAN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  pt_flt_decoder_if.slave  bus
);

  localparam int WORK_W = MAN_W + INT_W;
  localparam logic [FLT_EXP_W-1:0] EXP_LO = BIAS[FLT_EXP_W-1:0];
  localparam logic [FLT_EXP_W-1:0] EXP_HI = EXP_LO + 8'd7;
  localparam logic [1:0] DIG_LAST = 2'(FRAC_DIGITS - 1);

  state_t               state;
  logic [15:0]          flt_q;
  logic [WORK_W-1:0]    work;
  logic [2:0]           cnt;
  logic [1:0]           dcnt;
  logic [MAN_W-1:0]     fr;
  logic [DEC_W-1:0]     dec;

  logic                 busy_q;
  logic                 done_q;
  logic [INT_W-1:0]     int_q;
  logic [MAN_W-1:0]     frac_bin_q;
  logic [DEC_W-1:0]     frac_dec_q;
  logic                 sign_q;
  logic                 exp_err_q;
  logic                 zf_q;

  logic [FLT_EXP_W-1:0] exp_f;
  logic [MAN_W-1:0]     man_f;
  logic [WORK_W-1:0]    work_sh;
  logic [3:0]           digit;
  logic [MAN_W-1:0]     fr_next;
  logic [DEC_W-1:0]     dec_next;

  assign exp_f    = flt_q[EXP_MSB:EXP_LSB];
  assign man_f    = flt_q[MAN_W-1:0];
  assign work_sh  = {work[WORK_W-2:0], 1'b0};
  assign dec_next = (dec << 3) + (dec << 1) + {{(DEC_W-4){1'b0}}, digit};

  frac_digit_step #(.MAN_W(MAN_W)) u_step (
    .fr      (fr),
    .digit   (digit),
    .fr_next (fr_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      flt_q      <= '0;
      work       <= '0;
      cnt        <= '0;
      dcnt       <= '0;
      fr         <= '0;
      dec        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      int_q      <= '0;
      frac_bin_q <= '0;
      frac_dec_q <= '0;
      sign_q     <= 1'b0;
      exp_err_q  <= 1'b0;
      zf_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            flt_q  <= bus.flt_in;
            busy_q <= 1'b1;
            state  <= S_UNPACK;
          end
        end

        S_UNPACK: begin
          if (exp_f == '0 && man_f == '0) begin
            int_q      <= '0;
            frac_bin_q <= '0;
            frac_dec_q <= '0;
            sign_q     <= flt_q[SIGN_BIT];
            exp_err_q  <= 1'b0;
            zf_q       <= 1'b1;
            done_q     <= 1'b1;
            state      <= S_DONE;
          end else if (exp_f < EXP_LO || exp_f > EXP_HI) begin
            int_q      <= '0;
            frac_bin_q <= '0;
            frac_dec_q <= '0;
            sign_q     <= flt_q[SIGN_BIT];
            exp_err_q  <= 1'b1;
            zf_q       <= 1'b0;
            done_q     <= 1'b1;
            state      <= S_DONE;
          end else begin
            // Fixed point with MAN_W fraction bits; implicit leading one.
            work  <= {{(INT_W-1){1'b0}}, 1'b1, man_f};
            cnt   <= 3'(exp_f - EXP_LO);
            fr    <= man_f;
            dec   <= '0;
            dcnt  <= '0;
            state <= (exp_f == EXP_LO) ? S_DIGIT : S_ALIGN;
          end
        end

        S_ALIGN: begin
          work <= work_sh;
          cnt  <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            fr    <= work_sh[MAN_W-1:0];
            state <= S_DIGIT;
          end
        end

        S_DIGIT: begin
          // work stays frozen here, so it still holds the aligned value.
          fr   <= fr_next;
          dec  <= dec_next;
          dcnt <= dcnt + 2'd1;
          if (dcnt == DIG_LAST) begin
            int_q      <= work[WORK_W-1:MAN_W];
            frac_bin_q <= work[MAN_W-1:0];
            frac_dec_q <= dec_next;
            sign_q     <= flt_q[SIGN_BIT];
            exp_err_q  <= 1'b0;
            zf_q       <= 1'b0;
            done_q     <= 1'b1;
            state      <= S_DONE;
          end
        end

        S_DONE: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.int_out  = int_q;
  assign bus.frac_bin = frac_bin_q;
  assign bus.frac_dec = frac_dec_q;
  assign bus.sign_out = sign_q;
  assign bus.exp_err  = exp_err_q;
  assign bus.zf       = zf_q;

endmodule

// File: tb/tb_pt_flt_decoder.sv
// Scoreboard bench for pt_flt_decoder: directed words from the test plan plus
// randomized words checked against an arithmetic model of the float format.
module tb_pt_flt_decoder;

  localparam int FD = 2;

  typedef struct {
    logic [15:0] w;
    int iv, fb, fd, sg, er, z, lat, due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t m_e;

  pt_flt_decoder_if bus ();

  pt_flt_decoder #(.FRAC_DIGITS(FD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference: value = (1 + man/128) * 2^(exp-127), digits by exact truncation.
  function automatic exp_t model(input logic [15:0] w);
    exp_t r;
    int ex, m, e, scaled, frac, p10;
    r.w = w; r.sg = int'(w[15]); r.iv = 0; r.fb = 0; r.fd = 0; r.er = 0; r.z = 0;
    r.due = 0;
    ex = int'(w[14:7]);
    m  = int'(w[6:0]);
    if (ex == 0 && m == 0) begin
      r.z = 1; r.lat = 1;
    end else if (ex < 127 || ex > 134) begin
      r.er = 1; r.lat = 1;
    end else begin
      e = ex - 127;
      scaled = (128 + m) * (1 << e);
      r.iv = scaled / 128;
      frac = scaled % 128;
      r.fb = frac;
      p10 = 1;
      for (int i = 0; i < FD; i++) p10 = p10 * 10;
      r.fd = (frac * p10) / 128;
      r.lat = 1 + e + FD;
    end
    return r;
  endfunction

  function automatic exp_t lit(input logic [15:0] w, input int iv, input int fb,
                               input int fd, input int sg, input int er,
                               input int z, input int lat);
    exp_t r;
    r.w = w; r.iv = iv; r.fb = fb; r.fd = fd; r.sg = sg; r.er = er; r.z = z;
    r.lat = lat; r.due = 0;
    return r;
  endfunction

  task automatic issue(input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("idle_before_start", int'(bus.busy), 0);
    bus.start  = 1'b1;
    bus.flt_in = e.w;
    @(posedge clk);
    #1;
    e.due = cyc + e.lat;
    sb.push_back(e);
    chk("busy_after_start", int'(bus.busy), 1);
    bus.start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
      end else begin
        m_e = sb.pop_front();
        chk("done_cycle", cyc, m_e.due);
        chk("int_out", int'(bus.int_out), m_e.iv);
        chk("frac_bin", int'(bus.frac_bin), m_e.fb);
        chk("frac_dec", int'(bus.frac_dec), m_e.fd);
        chk("sign_out", int'(bus.sign_out), m_e.sg);
        chk("exp_err", int'(bus.exp_err), m_e.er);
        chk("zf", int'(bus.zf), m_e.z);
        chk("busy_in_done", int'(bus.busy), 1);
      end
    end
  end

  initial begin
    logic [15:0] w;
    int n;
    bus.start  = 1'b0;
    bus.flt_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_int_out", int'(bus.int_out), 0);
    chk("rst_frac_dec", int'(bus.frac_dec), 0);
    chk("rst_zf", int'(bus.zf), 0);
    rst_n = 1'b1;

    issue(lit(16'h40A8, 5, 8'h20, 25, 0, 0, 0, 5));
    issue(lit(16'h3FC0, 1, 8'h40, 50, 0, 0, 0, 3));
    issue(lit(16'h437F, 255, 0, 0, 0, 0, 0, 10));
    issue(lit(16'h0000, 0, 0, 0, 0, 0, 1, 1));
    issue(lit(16'h8000, 0, 0, 0, 1, 0, 1, 1));
    issue(lit(16'h4380, 0, 0, 0, 0, 1, 0, 1));
    issue(lit(16'hC0A8, 5, 8'h20, 25, 1, 0, 0, 5));
    issue(lit(16'h3F8D, 1, 13, 10, 0, 0, 0, 3));

    // start pulses while busy must be ignored
    issue(lit(16'h40A8, 5, 8'h20, 25, 0, 0, 0, 5));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.start  = 1'b1;
      bus.flt_in = 16'h437F;
    end
    @(negedge clk);
    bus.start = 1'b0;

    // asynchronous reset in the middle of ALIGN
    issue(model(16'h437F));
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_busy", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_int_out", int'(bus.int_out), 0);
    chk("arst_frac_bin", int'(bus.frac_bin), 0);
    chk("arst_frac_dec", int'(bus.frac_dec), 0);
    chk("arst_done", int'(bus.done), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue(model(16'h40A8));

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0:       w = {1'($urandom_range(0, 1)), 15'h0000};
        1:       w = 16'($urandom);
        default: w = {1'($urandom_range(0, 1)), 8'(127 + $urandom_range(0, 7)),
                      7'($urandom_range(0, 127))};
      endcase
      issue(model(w));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
